wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 64-bit RISC-V pipeline. It sits directly upstream of the register file and owns its single write port. It accepts retiring instructions from the memory stage and holds loads until the data-memory response returns. Load data is aligned and sign- or zero-extended before the write, and the stage also exposes a bypass copy of each write and a retired-instruction counter.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_sync_n  in  1  reset, synchronous, active-low.
- mem_valid_i  in  1  memory stage presents a retiring instruction.
- mem_ready_o  out  1  stage can accept; equals (state==IDLE) && rst_sync_n.
- mem_rd_addr_i  in  5  destination register.
- mem_rd_wr_i  in  1  instruction writes rd.
- mem_is_load_i  in  1  instruction is a load.
- mem_funct3_i  in  3  load size/sign code.
- mem_byte_off_i  in  3  load address bits [2:0].
- mem_result_i  in  64  ALU/CSR result for non-loads.
- ld_rsp_valid_i  in  1  data-memory response valid, one pulse per load.
- ld_rsp_data_i  in  64  raw aligned 64-bit memory doubleword.
- wr_en_o  out  1  register-file write enable.
- rd_addr_o  out  5  register-file write address.
- rd_data_o  out  64  register-file write data.
- instret_o  out  64  count of retired instructions.
- rsp_err_o  out  1  sticky protocol/decode error flag.

## Operation
- The FSM has two states, IDLE and WAIT_LOAD. Reset goes to IDLE.
- A handshake occurs on mem_valid_i && mem_ready_o. The stage latches rd_addr, rd_wr, funct3, byte_off and result.
- Non-load handshake:
  - State stays IDLE.
  - Next cycle: wr_en_o = mem_rd_wr_i && (rd != 0); rd_addr_o = rd; rd_data_o = result.
  - instret increments.
- Load handshake:
  - State goes to WAIT_LOAD and mem_ready_o drops.
  - On ld_rsp_valid_i in WAIT_LOAD, the formatted data is written the next cycle, gated the same way as a non-load.
  - instret increments and state returns to IDLE.
- Load formatting, funct3 → result:
  - 000 LB: byte at off[2:0], sign-extended.
  - 001 LH: half at off[2:1], sign-extended.
  - 010 LW: word at off[2], sign-extended.
  - 011 LD: full doubleword; off ignored.
  - 100 LBU, 101 LHU, 110 LWU: as above, zero-extended.
  - 111: result 0 and rsp_err_o sets.
- Misaligned low offset bits are truncated as listed above; alignment checking belongs to the memory stage.
- Writes to x0 are suppressed (wr_en_o=0) but still count in instret. A load to x0 still waits for and consumes its response.
- ld_rsp_valid_i while in IDLE is ignored and sets rsp_err_o. rsp_err_o clears only on reset.
- wr_en_o, rd_addr_o and rd_data_o are registered and are the bypass source for decode, because the register-file read path does not see a same-cycle write.
- instret_o wraps modulo 2^64.

## Timing
- Reset values: state IDLE, wr_en_o=0, rd_addr_o=0, rd_data_o=0, instret_o=0, rsp_err_o=0, mem_ready_o=0 while reset is asserted.
- Non-load accepted at cycle T: write visible in T+1. Throughput is one per cycle with no bubbles.
- Load accepted at T with response at T+k (k≥1): write visible in T+k+1 and mem_ready_o=1 again in T+k+1.
  - A response in the same cycle as the handshake (k=0) is illegal. It is treated as an IDLE response: ignored and rsp_err_o set.
- wr_en_o is high for exactly one cycle per writing instruction. It is 0 in every cycle with no retirement.
- instret_o updates in the same cycle wr_en_o would assert.
- Reset asserted while in WAIT_LOAD: the pending load is dropped, no write occurs, and a response arriving later is ignored and sets rsp_err_o.
- mem_valid_i while mem_ready_o=0: no effect; upstream holds its inputs.

## Structure
- Shared package riscv_pkg:
  - XLEN constant.
  - load_funct3_e enum (LB, LH, LW, LD, LBU, LHU, LWU).
  - wb_state_e enum (IDLE, WAIT_LOAD).
- Sub-module load_align: purely combinational (funct3, byte_off, raw data) → 64-bit result plus illegal flag. It is instantiated once.
- The top level holds the FSM, the latched request fields, the output registers and the instret counter.

## Test plan
- Reset, then two back-to-back non-loads.
  - Stimulus: rd=5 with 0x1234, then rd=6 with 0xFFFF_FFFF_FFFF_FFFF.
  - Response: writes in consecutive cycles, instret_o=2.
- LB, byte_off=3, response data 0x0000_0000_8000_0000 after k=3 cycles.
  - Response: rd_data_o=0xFFFF_FFFF_FFFF_FF80 in cycle T+4; mem_ready_o low T+1..T+3.
- LWU, byte_off=4, data 0xDEAD_BEEF_0000_0001.
  - Response: rd_data_o=0x0000_0000_DEAD_BEEF.
- Non-load to rd=0, then LD to rd=0.
  - Response: wr_en_o never asserts; instret_o=2.
- Edge cases:
  - ld_rsp_valid_i pulse in IDLE: rsp_err_o=1, no write.
  - Load with funct3=111: rd_data_o=0 and rsp_err_o=1.
- rst_sync_n pulled low in WAIT_LOAD, then response arrives after release.
  - Response: all outputs at reset values, no write, rsp_err_o=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and enums for the RV64 writeback stage.
package riscv_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment and sign/zero extension.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_byte_off,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_result_c,
  output logic            o_illegal_c
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;

  // Low offset bits below the access size are dropped, not checked.
  always_comb begin
    w_shamt = 6'd0;
    case (i_funct3)
      LB, LBU: w_shamt = {i_byte_off, 3'b000};
      LH, LHU: w_shamt = {i_byte_off[2:1], 4'b0000};
      LW, LWU: w_shamt = {i_byte_off[2], 5'b00000};
      default: w_shamt = 6'd0;
    endcase
  end

  assign w_shifted = i_data >> w_shamt;

  always_comb begin
    o_result_c  = '0;
    o_illegal_c = 1'b0;
    case (i_funct3)
      LB:  o_result_c = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      LH:  o_result_c = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      LW:  o_result_c = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      LD:  o_result_c = w_shifted;
      LBU: o_result_c = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      LHU: o_result_c = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      LWU: o_result_c = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: owns the register-file write port, waits on load
// responses, and keeps the retired-instruction counter.
module wb_stage #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_sync_n,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_wr_i,
  input  logic            mem_is_load_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [2:0]      mem_byte_off_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic            ld_rsp_valid_i,
  input  logic [XLEN-1:0] ld_rsp_data_i,
  output logic            wr_en_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [63:0]     instret_o,
  output logic            rsp_err_o
);

  import riscv_pkg::*;

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;

  logic [4:0]      r_rd_addr;
  logic            r_rd_wr;
  logic [2:0]      r_funct3;
  logic [2:0]      r_byte_off;

  logic            w_hs;
  logic            w_retire;
  logic            w_wr_en;
  logic [4:0]      w_addr;
  logic [XLEN-1:0] w_data;
  logic            w_err_set;

  logic [XLEN-1:0] w_align_data;
  logic            w_align_illegal;

  assign mem_ready_o = (r_state == IDLE) && rst_sync_n;
  assign w_hs        = mem_valid_i && mem_ready_o;

  load_align u_load_align (
    .i_funct3    (r_funct3),
    .i_byte_off  (r_byte_off),
    .i_data      (ld_rsp_data_i),
    .o_result_c  (w_align_data),
    .o_illegal_c (w_align_illegal)
  );

  // Next state and the values to register as this cycle's retirement.
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_wr_en     = 1'b0;
    w_addr      = rd_addr_o;
    w_data      = rd_data_o;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        // A response here is stray, including one coincident with a handshake.
        if (ld_rsp_valid_i) w_err_set = 1'b1;
        if (w_hs) begin
          if (mem_is_load_i) begin
            w_state_nxt = WAIT_LOAD;
          end else begin
            w_retire = 1'b1;
            w_wr_en  = mem_rd_wr_i && (mem_rd_addr_i != 5'd0);
            w_addr   = mem_rd_addr_i;
            w_data   = mem_result_i;
          end
        end
      end
      WAIT_LOAD: begin
        if (ld_rsp_valid_i) begin
          w_state_nxt = IDLE;
          w_retire    = 1'b1;
          w_wr_en     = r_rd_wr && (r_rd_addr != 5'd0);
          w_addr      = r_rd_addr;
          w_data      = w_align_data;
          w_err_set   = w_align_illegal;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched request fields for a pending load.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      r_rd_addr  <= 5'd0;
      r_rd_wr    <= 1'b0;
      r_funct3   <= 3'd0;
      r_byte_off <= 3'd0;
    end else if (w_hs) begin
      r_rd_addr  <= mem_rd_addr_i;
      r_rd_wr    <= mem_rd_wr_i;
      r_funct3   <= mem_funct3_i;
      r_byte_off <= mem_byte_off_i;
    end
  end

  // Write-port registers double as the decode bypass source.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      wr_en_o   <= 1'b0;
      rd_addr_o <= 5'd0;
      rd_data_o <= '0;
      instret_o <= 64'd0;
      rsp_err_o <= 1'b0;
    end else begin
      wr_en_o <= w_wr_en;
      if (w_retire) begin
        rd_addr_o <= w_addr;
        rd_data_o <= w_data;
        instret_o <= instret_o + 64'd1;
      end
      if (w_err_set) rsp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage.
module tb_wb_stage;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_sync_n;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_wr_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic [2:0]  mem_byte_off_i;
  logic [63:0] mem_result_i;
  logic        ld_rsp_valid_i;
  logic [63:0] ld_rsp_data_i;
  logic        wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic [63:0] instret_o;
  logic        rsp_err_o;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];

  wb_stage #(.XLEN(64)) dut (
    .clk            (clk),
    .rst_sync_n     (rst_sync_n),
    .mem_valid_i    (mem_valid_i),
    .mem_ready_o    (mem_ready_o),
    .mem_rd_addr_i  (mem_rd_addr_i),
    .mem_rd_wr_i    (mem_rd_wr_i),
    .mem_is_load_i  (mem_is_load_i),
    .mem_funct3_i   (mem_funct3_i),
    .mem_byte_off_i (mem_byte_off_i),
    .mem_result_i   (mem_result_i),
    .ld_rsp_valid_i (ld_rsp_valid_i),
    .ld_rsp_data_i  (ld_rsp_data_i),
    .wr_en_o        (wr_en_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_o      (rd_data_o),
    .instret_o      (instret_o),
    .rsp_err_o      (rsp_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then retire any visible write against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (wr_en_o !== 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr_en", 64'(wr_en_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 64'(rd_addr_o), 64'(e.addr));
        check("wr_data", rd_data_o, e.data);
      end
    end
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic wr, input logic ld,
                          input logic [2:0] f3, input logic [2:0] off,
                          input logic [63:0] res);
    mem_valid_i    = 1'b1;
    mem_rd_addr_i  = rd;
    mem_rd_wr_i    = wr;
    mem_is_load_i  = ld;
    mem_funct3_i   = f3;
    mem_byte_off_i = off;
    mem_result_i   = res;
  endtask

  task automatic do_reset();
    rst_sync_n = 1'b0;
    tick();
    rst_sync_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_sync_n     = 1'b0;
    mem_valid_i    = 1'b0;
    mem_rd_addr_i  = 5'd0;
    mem_rd_wr_i    = 1'b0;
    mem_is_load_i  = 1'b0;
    mem_funct3_i   = 3'd0;
    mem_byte_off_i = 3'd0;
    mem_result_i   = 64'd0;
    ld_rsp_valid_i = 1'b0;
    ld_rsp_data_i  = 64'd0;

    // Reset values
    tick();
    tick();
    check("rst_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_rd_addr", 64'(rd_addr_o), 64'd0);
    check("rst_rd_data", rd_data_o, 64'd0);
    check("rst_instret", instret_o, 64'd0);
    check("rst_err", 64'(rsp_err_o), 64'd0);
    check("rst_ready", 64'(mem_ready_o), 64'd0);
    rst_sync_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(mem_ready_o), 64'd1);

    // Back-to-back non-loads
    drive_op(5'd5, 1'b1, 1'b0, 3'd0, 3'd0, 64'h1234);
    sb_q.push_back('{addr: 5'd5, data: 64'h1234});
    tick();
    check("nl0_wr_en", 64'(wr_en_o), 64'd1);
    drive_op(5'd6, 1'b1, 1'b0, 3'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    sb_q.push_back('{addr: 5'd6, data: 64'hFFFF_FFFF_FFFF_FFFF});
    tick();
    check("nl1_wr_en", 64'(wr_en_o), 64'd1);
    mem_valid_i = 1'b0;
    tick();
    check("nl_idle_wr_en", 64'(wr_en_o), 64'd0);
    check("nl_instret", instret_o, 64'd2);

    // LB off=3, response after k=3
    drive_op(5'd7, 1'b1, 1'b1, 3'b000, 3'd3, 64'hAAAA);
    tick();
    mem_valid_i = 1'b0;
    check("lb_ready_t1", 64'(mem_ready_o), 64'd0);
    tick();
    check("lb_ready_t2", 64'(mem_ready_o), 64'd0);
    check("lb_no_wr", 64'(wr_en_o), 64'd0);
    tick();
    check("lb_ready_t3", 64'(mem_ready_o), 64'd0);
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 64'h0000_0000_8000_0000;
    sb_q.push_back('{addr: 5'd7, data: 64'hFFFF_FFFF_FFFF_FF80});
    tick();
    ld_rsp_valid_i = 1'b0;
    check("lb_wr_en", 64'(wr_en_o), 64'd1);
    check("lb_ready_t4", 64'(mem_ready_o), 64'd1);

    // LWU off=4, k=1
    drive_op(5'd8, 1'b1, 1'b1, 3'b110, 3'd4, 64'd0);
    tick();
    mem_valid_i    = 1'b0;
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 64'hDEAD_BEEF_0000_0001;
    sb_q.push_back('{addr: 5'd8, data: 64'h0000_0000_DEAD_BEEF});
    tick();
    ld_rsp_valid_i = 1'b0;
    check("lwu_wr_en", 64'(wr_en_o), 64'd1);
    check("lwu_instret", instret_o, 64'd4);

    // Writes to x0 are suppressed but still retire
    drive_op(5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'h55);
    tick();
    check("x0_nl_wr_en", 64'(wr_en_o), 64'd0);
    drive_op(5'd0, 1'b1, 1'b1, 3'b011, 3'd0, 64'd0);
    tick();
    mem_valid_i    = 1'b0;
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 64'h0123_4567_89AB_CDEF;
    tick();
    ld_rsp_valid_i = 1'b0;
    check("x0_ld_wr_en", 64'(wr_en_o), 64'd0);
    check("x0_instret", instret_o, 64'd6);
    check("x0_ready", 64'(mem_ready_o), 64'd1);
    check("err_clean", 64'(rsp_err_o), 64'd0);

    // Stray response in IDLE
    ld_rsp_valid_i = 1'b1;
    tick();
    ld_rsp_valid_i = 1'b0;
    check("stray_err", 64'(rsp_err_o), 64'd1);
    check("stray_wr_en", 64'(wr_en_o), 64'd0);
    check("stray_instret", instret_o, 64'd6);
    tick();
    check("stray_err_sticky", 64'(rsp_err_o), 64'd1);

    // Illegal funct3 load
    do_reset();
    check("rst2_err", 64'(rsp_err_o), 64'd0);
    check("rst2_instret", instret_o, 64'd0);
    drive_op(5'd9, 1'b1, 1'b1, 3'b111, 3'd0, 64'd0);
    tick();
    mem_valid_i    = 1'b0;
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 64'hFFFF_0000_FFFF_0000;
    sb_q.push_back('{addr: 5'd9, data: 64'd0});
    tick();
    ld_rsp_valid_i = 1'b0;
    check("ill_data", rd_data_o, 64'd0);
    check("ill_err", 64'(rsp_err_o), 64'd1);

    // Reset while waiting on a load, response arrives afterward
    do_reset();
    drive_op(5'd10, 1'b1, 1'b1, 3'b011, 3'd0, 64'd0);
    tick();
    mem_valid_i = 1'b0;
    rst_sync_n  = 1'b0;
    tick();
    check("wrst_wr_en", 64'(wr_en_o), 64'd0);
    check("wrst_rd_addr", 64'(rd_addr_o), 64'd0);
    check("wrst_rd_data", rd_data_o, 64'd0);
    check("wrst_instret", instret_o, 64'd0);
    check("wrst_err", 64'(rsp_err_o), 64'd0);
    check("wrst_ready", 64'(mem_ready_o), 64'd0);
    rst_sync_n = 1'b1;
    tick();
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 64'h1111_2222_3333_4444;
    tick();
    ld_rsp_valid_i = 1'b0;
    check("late_rsp_err", 64'(rsp_err_o), 64'd1);
    check("late_rsp_wr_en", 64'(wr_en_o), 64'd0);
    check("late_rsp_rd_addr", 64'(rd_addr_o), 64'd0);
    check("late_rsp_rd_data", rd_data_o, 64'd0);
    check("late_rsp_instret", instret_o, 64'd0);
    check("late_rsp_ready", 64'(mem_ready_o), 64'd1);

    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
